pht_port_scheduler: RTL and testbench
=====================================

Name: pht_port_scheduler

Overview:
- Schedules the single-port pattern-history-table (PHT) SRAM of the pipelined core's branch predictor (two-bit, gshare and agree variants).
- Arbitrates each cycle between IF-stage prediction lookups and EX-stage resolution updates. Buffers updates in a small FIFO and forwards pending updates to lookups.
- Prevents update starvation with a bounded deferral counter.
- Sits between the predictor index logic and the PHT SRAM macro.

Parameters:
- INDEX_WIDTH, 10: PHT index width; the table has 2^INDEX_WIDTH 2-bit entries.
- UPD_DEPTH, 4: update FIFO depth; power of two, at least 2.
- MAX_DEFER, 8: maximum number of consecutive cycles a non-empty FIFO may go without a write; at least 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lk_req_i  in  1  lookup request (IF)
- lk_idx_i  in  INDEX_WIDTH  lookup index
- lk_gnt_o  out  1  lookup accepted this cycle (combinational)
- lk_vld_o  out  1  lookup response valid (one cycle after grant)
- lk_ctr_o  out  2  counter value returned by the lookup
- lk_taken_o  out  1  prediction; equals lk_ctr_o[1]
- up_vld_i  in  1  update valid (EX resolution)
- up_idx_i  in  INDEX_WIDTH  update index
- up_taken_i  in  1  resolved branch outcome
- up_ctr_i  in  2  counter value carried down the pipeline from lookup
- up_rdy_o  out  1  update accepted; equals not full
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  INDEX_WIDTH  SRAM address
- mem_wdata_o  out  2  SRAM write data
- mem_rdata_i  in  2  SRAM read data; valid the cycle after a read
- fifo_cnt_o  out  clog2(UPD_DEPTH)+1  FIFO occupancy, for debug

Behaviour:
- Enqueue: when up_vld_i and up_rdy_o, push {up_idx_i, nctr}.
  - nctr = up_taken_i ? min(up_ctr_i+1, 3) : max(up_ctr_i-1, 0).
  - 2-bit saturating arithmetic; never wraps.
- Full FIFO: up_rdy_o = 0. Enqueue is blocked even if a dequeue occurs in the same cycle.
- Per-cycle port decision, first match wins:
  1. FIFO full, or defer_cnt == MAX_DEFER: write the head entry; lk_gnt_o = 0.
  2. lk_req_i: read lk_idx_i; lk_gnt_o = 1.
  3. FIFO non-empty: write the head entry.
  4. Otherwise idle: mem_en_o = 0.
- Memory port outputs:
  - Write: mem_en_o = 1, mem_we_o = 1, mem_addr_o = head idx, mem_wdata_o = head ctr; pop the head.
  - Read: mem_en_o = 1, mem_we_o = 0, mem_addr_o = lk_idx_i.
- defer_cnt:
  - Cleared on a write or when the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and no write occurs.
  - Saturates at MAX_DEFER.
- Lookup latency is 1 cycle. lk_vld_o is registered and equals the previous cycle's lk_gnt_o.
- Forwarding:
  - At grant, compare lk_idx_i against all valid FIFO entries present at the start of that cycle.
  - On a match, register the youngest matching entry's ctr. lk_ctr_o then uses the registered value instead of mem_rdata_i.
  - An update enqueued in the same cycle as the grant is NOT forwarded.
- No write can coincide with a read, because the port is single.
- Ungranted lookups are not queued; the requester holds lk_req_i, and IF stalls on !lk_gnt_o.
- Reset: FIFO empty, defer_cnt = 0, lk_vld_o = 0, lk_ctr_o = 2'b01, up_rdy_o = 1 in the following cycle, mem_en_o = 0.
- Reset mid-operation: pending updates are dropped and any in-flight lookup response is discarded.
- FIFO pointers wrap modulo UPD_DEPTH. Occupancy is exact through full/empty transitions.

Test Plan:
- Basic update: after reset, lk_req_i = 0, one update idx = 5, taken = 1, ctr = 2'b01 → next cycle write addr 5, data 2'b10, fifo_cnt_o returns to 0.
- Saturation: update ctr = 2'b11 taken → write 2'b11; ctr = 2'b00 not-taken → write 2'b00.
- Forwarding and same-cycle rule:
  - With lk_req_i held high, enqueue idx = 7 (ctr 2'b10 taken), then look up idx 7 → lk_ctr_o = 2'b11 regardless of mem_rdata_i.
  - Lookup in the same cycle as enqueue of idx 7 → lk_ctr_o = mem_rdata_i.
- Starvation: lk_req_i held high, one update queued, MAX_DEFER = 8 → exactly 8 lookups granted, 9th cycle lk_gnt_o = 0 and a write occurs, then grants resume.
- Full FIFO: lk_req_i high, 4 back-to-back updates.
  - → up_rdy_o = 0 after the 4th; next cycle a forced write and lk_gnt_o = 0.
  - A 5th update presented while full is not accepted until up_rdy_o = 1.
- Reset mid-operation: assert rst_i with 3 queued updates and a granted lookup → no writes issued afterwards, lk_vld_o = 0, fifo_cnt_o = 0.

Source files
------------

// File: rtl/pht_port_scheduler.sv
// rtl/pht_port_scheduler.sv - single-port PHT SRAM scheduler with update FIFO, forwarding and starvation guard
module pht_port_scheduler #(
    parameter int INDEX_WIDTH = 10,
    parameter int UPD_DEPTH   = 4,
    parameter int MAX_DEFER   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             lk_req_i,
    input  logic [INDEX_WIDTH-1:0]           lk_idx_i,
    output logic                             lk_gnt_o,
    output logic                             lk_vld_o,
    output logic [1:0]                       lk_ctr_o,
    output logic                             lk_taken_o,
    input  logic                             up_vld_i,
    input  logic [INDEX_WIDTH-1:0]           up_idx_i,
    input  logic                             up_taken_i,
    input  logic [1:0]                       up_ctr_i,
    output logic                             up_rdy_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [INDEX_WIDTH-1:0]           mem_addr_o,
    output logic [1:0]                       mem_wdata_o,
    input  logic [1:0]                       mem_rdata_i,
    output logic [$clog2(UPD_DEPTH):0]       fifo_cnt_o
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    logic [INDEX_WIDTH-1:0] q_idx [UPD_DEPTH];
    logic [1:0]             q_ctr [UPD_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       cnt;
    logic [DEF_W-1:0]       defer_cnt;

    logic       vld_q;
    logic       fwd_hit_q;
    logic [1:0] fwd_ctr_q;
    logic [1:0] hold_ctr_q;

    logic             full;
    logic             empty;
    logic             force_wr;
    logic             do_wr;
    logic             gnt;
    logic             push;
    logic [1:0]       nctr;
    logic             fwd_hit;
    logic [1:0]       fwd_ctr;
    logic [PTR_W-1:0] slot;

    assign full  = (cnt == CNT_W'(UPD_DEPTH));
    assign empty = (cnt == '0);

    // Port decision: forced drain beats lookups, lookups beat opportunistic drain.
    // Everything is gated during reset so stale queue contents never reach the SRAM.
    always_comb begin
        force_wr = full || ((defer_cnt == DEF_W'(MAX_DEFER)) && !empty);
        do_wr    = !rst_i && (force_wr || (!lk_req_i && !empty));
        gnt      = !rst_i && lk_req_i && !force_wr;
        push     = !rst_i && up_vld_i && !full;
    end

    // Two-bit saturating counter step for the incoming resolution.
    always_comb begin
        nctr = up_ctr_i;
        if (up_taken_i) begin
            if (up_ctr_i != 2'b11) nctr = up_ctr_i + 2'b01;
        end else begin
            if (up_ctr_i != 2'b00) nctr = up_ctr_i - 2'b01;
        end
    end

    // Scan queued entries oldest to youngest so the youngest match is left standing.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_ctr = 2'b00;
        slot    = '0;
        for (int i = 0; i < UPD_DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && (q_idx[slot] == lk_idx_i)) begin
                fwd_hit = 1'b1;
                fwd_ctr = q_ctr[slot];
            end
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_idx[wr_ptr] <= up_idx_i;
            q_ctr[wr_ptr] <= nctr;
        end
    end

    // Queue pointers, occupancy, deferral counter and lookup response state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            defer_cnt  <= '0;
            vld_q      <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_ctr_q  <= 2'b01;
            hold_ctr_q <= 2'b01;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_wr) rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(do_wr);

            if (do_wr || empty)
                defer_cnt <= '0;
            else if (defer_cnt != DEF_W'(MAX_DEFER))
                defer_cnt <= defer_cnt + DEF_W'(1);

            vld_q <= gnt;
            if (gnt) begin
                fwd_hit_q <= fwd_hit;
                fwd_ctr_q <= fwd_ctr;
            end
            if (vld_q) hold_ctr_q <= lk_ctr_o;
        end
    end

    assign lk_gnt_o    = gnt;
    assign lk_vld_o    = vld_q;
    assign lk_ctr_o    = vld_q ? (fwd_hit_q ? fwd_ctr_q : mem_rdata_i) : hold_ctr_q;
    assign lk_taken_o  = lk_ctr_o[1];
    assign up_rdy_o    = !full && !rst_i;
    assign mem_en_o    = do_wr || gnt;
    assign mem_we_o    = do_wr;
    assign mem_addr_o  = do_wr ? q_idx[rd_ptr] : lk_idx_i;
    assign mem_wdata_o = do_wr ? q_ctr[rd_ptr] : 2'b00;
    assign fifo_cnt_o  = cnt;

endmodule

// File: tb/tb_pht_port_scheduler.sv
// tb/tb_pht_port_scheduler.sv - self-checking bench for pht_port_scheduler
module tb_pht_port_scheduler;

    localparam int IW = 10;
    localparam int D  = 4;
    localparam int MD = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          lk_req_i;
    logic [IW-1:0] lk_idx_i;
    logic          lk_gnt_o;
    logic          lk_vld_o;
    logic [1:0]    lk_ctr_o;
    logic          lk_taken_o;
    logic          up_vld_i;
    logic [IW-1:0] up_idx_i;
    logic          up_taken_i;
    logic [1:0]    up_ctr_i;
    logic          up_rdy_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [IW-1:0] mem_addr_o;
    logic [1:0]    mem_wdata_o;
    logic [1:0]    mem_rdata_i;
    logic [2:0]    fifo_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       use_rand = 1'b0;
    logic [1:0] rand_rdata = 2'b00;
    logic       sram_clear = 1'b0;
    logic [1:0] sram [1024];
    logic [1:0] sram_q = 2'b00;
    int         ref_tbl [1024];

    always #5 clk = ~clk;

    pht_port_scheduler #(.INDEX_WIDTH(IW), .UPD_DEPTH(D), .MAX_DEFER(MD)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .lk_req_i(lk_req_i), .lk_idx_i(lk_idx_i), .lk_gnt_o(lk_gnt_o),
        .lk_vld_o(lk_vld_o), .lk_ctr_o(lk_ctr_o), .lk_taken_o(lk_taken_o),
        .up_vld_i(up_vld_i), .up_idx_i(up_idx_i), .up_taken_i(up_taken_i),
        .up_ctr_i(up_ctr_i), .up_rdy_o(up_rdy_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .fifo_cnt_o(fifo_cnt_o)
    );

    // Behavioural single-port SRAM, read data valid the cycle after the read.
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 2'b01;
        end else if (mem_en_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else          sram_q <= sram[mem_addr_o];
        end
    end

    assign mem_rdata_i = use_rand ? rand_rdata : sram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input int idx, input logic uv,
                         input int uidx, input logic ut, input int uc);
        lk_req_i   = req;
        lk_idx_i   = IW'(idx);
        up_vld_i   = uv;
        up_idx_i   = IW'(uidx);
        up_taken_i = ut;
        up_ctr_i   = 2'(uc);
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (fifo_cnt_o !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt_o); end
        n_cmp++; if (lk_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %0b want 0", lk_vld_o); end
        n_cmp++; if (lk_ctr_o !== 2'b01) begin n_fail++; $display("FAIL rst_ctr: got %0b want 01", lk_ctr_o); end
        n_cmp++; if (up_rdy_o !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %0b want 1", up_rdy_o); end
        n_cmp++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0b want 0", mem_en_o); end
        tick();
    endtask

    task automatic test_random();
        int q_idx[$];
        int q_ctr[$];
        int defer;
        int sz;
        bit full, force_wr, wr, gnt;
        int v;
        int n;
        logic req, uv, ut;
        int idx, uidx, uc;
        apply_reset();
        defer = 0;
        for (int c = 0; c < 400; c++) begin
            req  = ($urandom % 10) < 7;
            idx  = $urandom % 8;
            uv   = $urandom % 2;
            uidx = $urandom % 8;
            ut   = $urandom % 2;
            uc   = $urandom % 4;
            drive(req, idx, uv, uidx, ut, uc);
            #1;
            sz       = q_idx.size();
            full     = (sz == D);
            force_wr = full || (defer == MD);
            wr       = force_wr || (!req && sz > 0);
            gnt      = req && !force_wr;
            n_cmp++; if (lk_gnt_o !== gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %0b want %0b", c, lk_gnt_o, gnt); end
            n_cmp++; if (up_rdy_o !== !full) begin n_fail++; $display("FAIL rnd_rdy c%0d: got %0b want %0b", c, up_rdy_o, !full); end
            n_cmp++; if (fifo_cnt_o !== 3'(sz)) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, fifo_cnt_o, sz); end
            n_cmp++; if (mem_en_o !== (wr || gnt)) begin n_fail++; $display("FAIL rnd_en c%0d: got %0b want %0b", c, mem_en_o, wr || gnt); end
            if (wr) begin
                n_cmp++;
                if (mem_we_o !== 1'b1 || mem_addr_o !== IW'(q_idx[0]) || mem_wdata_o !== 2'(q_ctr[0])) begin
                    n_fail++;
                    $display("FAIL rnd_wr c%0d: got we=%0b a=%0d d=%0d want we=1 a=%0d d=%0d",
                             c, mem_we_o, mem_addr_o, mem_wdata_o, q_idx[0], q_ctr[0]);
                end
            end else if (gnt) begin
                n_cmp++;
                if (mem_we_o !== 1'b0 || mem_addr_o !== IW'(idx)) begin
                    n_fail++;
                    $display("FAIL rnd_rd c%0d: got we=%0b a=%0d want we=0 a=%0d", c, mem_we_o, mem_addr_o, idx);
                end
            end
            v = ref_tbl[idx];
            foreach (q_idx[k]) if (q_idx[k] == idx) v = q_ctr[k];
            tick();
            if (wr) begin
                ref_tbl[q_idx[0]] = q_ctr[0];
                void'(q_idx.pop_front());
                void'(q_ctr.pop_front());
            end
            if (wr || sz == 0) defer = 0;
            else if (defer < MD) defer++;
            if (uv && !full) begin
                n = ut ? uc + 1 : uc - 1;
                if (n > 3) n = 3;
                if (n < 0) n = 0;
                q_idx.push_back(uidx);
                q_ctr.push_back(n);
            end
            n_cmp++; if (lk_vld_o !== gnt) begin n_fail++; $display("FAIL rnd_vld c%0d: got %0b want %0b", c, lk_vld_o, gnt); end
            if (gnt) begin
                n_cmp++;
                if (lk_ctr_o !== 2'(v) || lk_taken_o !== 1'(v >> 1)) begin
                    n_fail++;
                    $display("FAIL rnd_ctr c%0d: got %0d/%0b want %0d", c, lk_ctr_o, lk_taken_o, v);
                end
            end
        end
    endtask

    task automatic test_basic_update();
        apply_reset();
        drive(0, 0, 1, 5, 1, 1);
        #1;
        n_cmp++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b want 0", mem_en_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (fifo_cnt_o !== 3'd1) begin n_fail++; $display("FAIL basic_cnt1: got %0d want 1", fifo_cnt_o); end
        n_cmp++;
        if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== IW'(5) || mem_wdata_o !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_wr: got en=%0b we=%0b a=%0d d=%0b want 1 1 5 10", mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        #1;
        n_cmp++; if (fifo_cnt_o !== 3'd0) begin n_fail++; $display("FAIL basic_cnt0: got %0d want 0", fifo_cnt_o); end
    endtask

    task automatic test_saturation();
        int ctr_t [3] = '{3, 0, 2};
        int tk_t  [3] = '{1, 0, 0};
        int exp_t [3] = '{3, 0, 1};
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            drive(0, 0, 1, 9 + k, 1'(tk_t[k]), ctr_t[k]);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            #1;
            n_cmp++;
            if (mem_we_o !== 1'b1 || mem_wdata_o !== 2'(exp_t[k])) begin
                n_fail++;
                $display("FAIL sat_%0d: got we=%0b d=%0d want we=1 d=%0d", k, mem_we_o, mem_wdata_o, exp_t[k]);
            end
            tick();
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        use_rand   = 1'b1;
        rand_rdata = 2'b00;
        drive(1, 3, 1, 7, 1, 2);
        #1;
        n_cmp++; if (lk_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fwd_gnt0: got %0b want 1", lk_gnt_o); end
        tick();
        drive(1, 7, 0, 0, 0, 0);
        #1;
        n_cmp++; if (lk_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fwd_gnt1: got %0b want 1", lk_gnt_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (lk_vld_o !== 1'b1 || lk_ctr_o !== 2'b11 || lk_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_hit: got vld=%0b ctr=%0b tk=%0b want 1 11 1", lk_vld_o, lk_ctr_o, lk_taken_o);
        end
        tick();
        rand_rdata = 2'b01;
        drive(1, 7, 1, 7, 1, 2);
        #1;
        n_cmp++; if (lk_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fwd_gnt2: got %0b want 1", lk_gnt_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (lk_vld_o !== 1'b1 || lk_ctr_o !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_same_cycle: got vld=%0b ctr=%0b want 1 01", lk_vld_o, lk_ctr_o);
        end
        tick();
        use_rand = 1'b0;
    endtask

    task automatic test_starvation();
        int  grants;
        bit  done;
        apply_reset();
        drive(1, $urandom % 1024, 1, 11, 1, 1);
        tick();
        drive(1, 21, 0, 0, 0, 0);
        grants = 0;
        done   = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (mem_en_o && mem_we_o) begin
                done = 1;
                n_cmp++; if (lk_gnt_o !== 1'b0) begin n_fail++; $display("FAIL starve_gnt_on_wr: got %0b want 0", lk_gnt_o); end
            end else if (lk_gnt_o) begin
                grants++;
            end
            tick();
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL starve_timeout: got no write want write within 20 cycles"); end
        n_cmp++; if (grants != MD) begin n_fail++; $display("FAIL starve_grants: got %0d want %0d", grants, MD); end
        #1;
        n_cmp++; if (lk_gnt_o !== 1'b1 || fifo_cnt_o !== 3'd0) begin n_fail++; $display("FAIL starve_resume: got gnt=%0b cnt=%0d want 1 0", lk_gnt_o, fifo_cnt_o); end
        tick();
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, $urandom % 1024, 1, 30 + k, 1, 0);
            #1;
            n_cmp++; if (up_rdy_o !== 1'b1 || lk_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got rdy=%0b gnt=%0b want 1 1", k, up_rdy_o, lk_gnt_o); end
            tick();
        end
        drive(1, 100, 1, 40, 0, 3);
        #1;
        n_cmp++;
        if (up_rdy_o !== 1'b0 || fifo_cnt_o !== 3'd4 || lk_gnt_o !== 1'b0 || mem_we_o !== 1'b1 || mem_addr_o !== IW'(30)) begin
            n_fail++;
            $display("FAIL full_forced: got rdy=%0b cnt=%0d gnt=%0b we=%0b a=%0d want 0 4 0 1 30",
                     up_rdy_o, fifo_cnt_o, lk_gnt_o, mem_we_o, mem_addr_o);
        end
        tick();
        #1;
        n_cmp++; if (up_rdy_o !== 1'b1 || fifo_cnt_o !== 3'd3 || lk_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got rdy=%0b cnt=%0d gnt=%0b want 1 3 1", up_rdy_o, fifo_cnt_o, lk_gnt_o); end
        tick();
        drive(1, 100, 0, 0, 0, 0);
        #1;
        n_cmp++; if (fifo_cnt_o !== 3'd4 || lk_gnt_o !== 1'b0) begin n_fail++; $display("FAIL full_once: got cnt=%0d gnt=%0b want 4 0", fifo_cnt_o, lk_gnt_o); end
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        int writes;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, $urandom % 1024, 1, 50 + k, 1, 1);
            tick();
        end
        drive(1, 51, 0, 0, 0, 0);
        #1;
        n_cmp++; if (lk_gnt_o !== 1'b1 || fifo_cnt_o !== 3'd3) begin n_fail++; $display("FAIL mid_setup: got gnt=%0b cnt=%0d want 1 3", lk_gnt_o, fifo_cnt_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (lk_vld_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin n_fail++; $display("FAIL mid_state: got vld=%0b cnt=%0d want 0 0", lk_vld_o, fifo_cnt_o); end
        writes = 0;
        repeat (6) begin
            if (mem_en_o) writes++;
            tick();
        end
        n_cmp++; if (writes != 0) begin n_fail++; $display("FAIL mid_writes: got %0d want 0", writes); end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        for (int i = 0; i < 1024; i++) ref_tbl[i] = 1;
        sram_clear = 1'b1;
        tick();
        tick();
        sram_clear = 1'b0;
        test_reset();
        test_random();
        test_basic_update();
        test_saturation();
        test_forwarding();
        test_starvation();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
